// File: rtl/pid_update_sequencer.sv
// pid_update_sequencer: divides clk down to the control sample rate, waits for
// a fresh sensor sample, then strobes each PID pipeline stage once, in order.
// Every output is registered. Overrun flags sample ticks that had to be dropped.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | waiting for the next sample tick
//   WAIT_DATA | tick seen without a fresh sample; waiting for sensor_valid
//   RUN       | one stage_en bit per cycle, stage 0 up to NUM_STAGES-1
//   DONE      | command register updated; update_done pulses for this cycle
module pid_update_sequencer #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sensor_valid,
  input  logic                  clear_req,
  input  logic                  clear_overrun,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  clr_n,
  output logic                  update_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  pending;
  logic                  pending_nxt;
  logic [NUM_STAGES-1:0] stage_en_nxt;
  logic                  update_done_nxt;
  logic                  busy_nxt;
  logic                  overrun_nxt;
  logic                  clr_n_nxt;
  logic                  tick;
  logic                  enter_run;
  logic                  set_overrun;

  // Sample-period tick: last count of the divider while running.
  assign tick = enable && (cnt == CNT_LAST);

  // Next-state and next-output logic; enable=0 overrides everything.
  always_comb begin
    state_nxt       = state;
    stage_en_nxt    = '0;
    update_done_nxt = 1'b0;
    enter_run       = 1'b0;
    set_overrun     = 1'b0;

    case (state)
      IDLE: begin
        if (tick) begin
          if (pending || sensor_valid) begin
            enter_run    = 1'b1;
            state_nxt    = RUN;
            stage_en_nxt = NUM_STAGES'(1);
          end else begin
            state_nxt = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        // A sample arriving on the tick cycle is taken, not counted as a miss.
        if (sensor_valid) begin
          enter_run    = 1'b1;
          state_nxt    = RUN;
          stage_en_nxt = NUM_STAGES'(1);
        end else if (tick) begin
          set_overrun = 1'b1;
        end
      end
      RUN: begin
        set_overrun = tick;
        if (stage_en[NUM_STAGES-1]) begin
          state_nxt       = DONE;
          update_done_nxt = 1'b1;
        end else begin
          stage_en_nxt = stage_en << 1;
        end
      end
      DONE: begin
        set_overrun = tick;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!enable) begin
      state_nxt       = IDLE;
      stage_en_nxt    = '0;
      update_done_nxt = 1'b0;
      enter_run       = 1'b0;
      set_overrun     = 1'b0;
    end

    busy_nxt  = (state_nxt != IDLE);
    clr_n_nxt = enable && !clear_req;

    if (!enable || tick) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    // A sample landing on the RUN-entry cycle belongs to the next period.
    if (!enable) begin
      pending_nxt = 1'b0;
    end else if (sensor_valid) begin
      pending_nxt = 1'b1;
    end else if (enter_run) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end

    // Set beats clear when both land in the same cycle.
    if (!enable) begin
      overrun_nxt = 1'b0;
    end else if (set_overrun) begin
      overrun_nxt = 1'b1;
    end else if (clear_overrun) begin
      overrun_nxt = 1'b0;
    end else begin
      overrun_nxt = overrun;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      stage_en    <= '0;
      update_done <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      clr_n       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending     <= pending_nxt;
      stage_en    <= stage_en_nxt;
      update_done <= update_done_nxt;
      busy        <= busy_nxt;
      overrun     <= overrun_nxt;
      clr_n       <= clr_n_nxt;
    end
  end

endmodule

// File: tb/tb_pid_update_sequencer.sv
// Bench for pid_update_sequencer: two instances (CLK_DIV 8 and 4) share the
// stimulus; a cycle-position model checks both every cycle, and tables plus
// short sequences cover the documented timing scenarios.
module tb_pid_update_sequencer;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset;
  logic en, sv, cr, co;
  logic [NS-1:0] st8, st4;
  logic cn8, cn4, ud8, ud4, bs8, bs4, ov8, ov4;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pid_update_sequencer #(.CLK_DIV(8), .NUM_STAGES(NS)) dut8 (
    .clk(clk), .reset(reset), .enable(en), .sensor_valid(sv),
    .clear_req(cr), .clear_overrun(co), .stage_en(st8), .clr_n(cn8),
    .update_done(ud8), .busy(bs8), .overrun(ov8)
  );

  pid_update_sequencer #(.CLK_DIV(4), .NUM_STAGES(NS)) dut4 (
    .clk(clk), .reset(reset), .enable(en), .sensor_valid(sv),
    .clear_req(cr), .clear_overrun(co), .stage_en(st4), .clr_n(cn4),
    .update_done(ud4), .busy(bs4), .overrun(ov4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within an update (0 none, 1..NS stages, NS+1 done).
  int m_cnt[2];
  int m_pos[2];
  bit m_wait[2], m_pend[2], m_ovr[2], m_clr[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0; m_pos[i] <= 0; m_wait[i] <= 1'b0;
        m_pend[i] <= 1'b0; m_ovr[i] <= 1'b0; m_clr[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic bit tk = (m_cnt[i] == div_of(i) - 1);
        automatic bit start = 1'b0;
        automatic bit miss = 1'b0;
        automatic int pos = m_pos[i];
        automatic bit wt = m_wait[i];
        if (!en) begin
          m_cnt[i] <= 0; m_pos[i] <= 0; m_wait[i] <= 1'b0;
          m_pend[i] <= 1'b0; m_ovr[i] <= 1'b0; m_clr[i] <= 1'b0;
        end else begin
          if (pos != 0) begin
            miss = tk;
            pos = (pos == NS + 1) ? 0 : pos + 1;
          end else if (wt) begin
            if (sv) start = 1'b1;
            else if (tk) miss = 1'b1;
          end else if (tk) begin
            if (m_pend[i] || sv) start = 1'b1;
            else wt = 1'b1;
          end
          if (start) begin
            wt = 1'b0;
            pos = 1;
          end
          m_cnt[i]  <= tk ? 0 : m_cnt[i] + 1;
          m_pos[i]  <= pos;
          m_wait[i] <= wt;
          m_pend[i] <= sv ? 1'b1 : (start ? 1'b0 : m_pend[i]);
          m_ovr[i]  <= miss ? 1'b1 : (co ? 1'b0 : m_ovr[i]);
          m_clr[i]  <= !cr;
        end
      end
    end
  end

  function automatic logic [NS-1:0] m_stage(input int i);
    if (m_pos[i] >= 1 && m_pos[i] <= NS) return NS'(1 << (m_pos[i] - 1));
    return '0;
  endfunction

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("model8 stage_en", 32'(st8), 32'(m_stage(0)));
      check("model8 clr_n", 32'(cn8), 32'(m_clr[0]));
      check("model8 update_done", 32'(ud8), 32'(m_pos[0] == NS + 1));
      check("model8 busy", 32'(bs8), 32'(m_pos[0] != 0 || m_wait[0]));
      check("model8 overrun", 32'(ov8), 32'(m_ovr[0]));
      check("model4 stage_en", 32'(st4), 32'(m_stage(1)));
      check("model4 clr_n", 32'(cn4), 32'(m_clr[1]));
      check("model4 update_done", 32'(ud4), 32'(m_pos[1] == NS + 1));
      check("model4 busy", 32'(bs4), 32'(m_pos[1] != 0 || m_wait[1]));
      check("model4 overrun", 32'(ov4), 32'(m_ovr[1]));
    end
  end

  typedef struct {
    logic          en, sv, cr, co;
    logic [NS-1:0] stage;
    logic          clr_n, done, busy, ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, s, input logic [NS-1:0] st,
                              input logic cn, ud, bs, ov);
    vec_t v;
    v.en = e; v.sv = s; v.cr = 1'b0; v.co = 1'b0;
    v.stage = st; v.clr_n = cn; v.done = ud; v.busy = bs; v.ovr = ov;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, s, c, o);
    en = e; sv = s; cr = c; co = o;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " stage_en8"}, 32'(st8), 32'd0);
    check({tag, " clr_n8"}, 32'(cn8), 32'd0);
    check({tag, " update_done8"}, 32'(ud8), 32'd0);
    check({tag, " busy8"}, 32'(bs8), 32'd0);
    check({tag, " overrun8"}, 32'(ov8), 32'd0);
    check({tag, " stage_en4"}, 32'(st4), 32'd0);
    check({tag, " busy4"}, 32'(bs4), 32'd0);
    check({tag, " clr_n4"}, 32'(cn4), 32'd0);
  endtask

  task automatic run_table(input int lo, input int hi, input string tag);
    for (int r = lo; r <= hi; r++) begin
      drive(tbl[r].en, tbl[r].sv, tbl[r].cr, tbl[r].co);
      @(negedge clk);
      check($sformatf("%s c%0d stage_en", tag, r - lo), 32'(st8), 32'(tbl[r].stage));
      check($sformatf("%s c%0d clr_n", tag, r - lo), 32'(cn8), 32'(tbl[r].clr_n));
      check($sformatf("%s c%0d update_done", tag, r - lo), 32'(ud8), 32'(tbl[r].done));
      check($sformatf("%s c%0d busy", tag, r - lo), 32'(bs8), 32'(tbl[r].busy));
      check($sformatf("%s c%0d overrun", tag, r - lo), 32'(ov8), 32'(tbl[r].ovr));
      step();
    end
  endtask

  initial begin
    // Early sample: tick at 7, strobes 8..11, done 12.
    for (int c = 0; c <= 13; c++)
      tbl.push_back(mk(1'b1, c == 2,
                       (c >= 8 && c <= 11) ? NS'(1 << (c - 8)) : NS'(0),
                       c >= 1, c == 12, c >= 8 && c <= 12, 1'b0));
    // Late sample at 10: WAIT_DATA from 8, strobes 11..14, done 15, tick 15 dropped.
    for (int c = 0; c <= 16; c++)
      tbl.push_back(mk(1'b1, c == 10,
                       (c >= 11 && c <= 14) ? NS'(1 << (c - 11)) : NS'(0),
                       c >= 1, c == 15, c >= 8 && c <= 15, c >= 16));

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_reset_vals("reset");
    #10 reset = 1'b0;
    step();
    chk_on = 1'b1;
    gap(2);

    run_table(0, 13, "early");
    gap(2);
    run_table(14, 30, "late");
    gap(2);

    // CLK_DIV=4 with data always pending: ticks fall in RUN and are dropped.
    for (int c = 0; c <= 24; c++) begin
      drive(1'b1, 1'b1, 1'b0, c == 9 || c == 23);
      @(negedge clk);
      if (c == 8 || c == 10 || c == 15 || c == 16 || c == 24)
        check($sformatf("ovr4 c%0d overrun", c), 32'(ov4),
              32'(c == 8 || c == 16 || c == 24));
      if (c == 4)
        check("ovr4 c4 stage_en", 32'(st4), 32'd1);
      step();
    end
    gap(2);

    // Abort at stage 2, then restart from stage 0.
    for (int c = 0; c <= 20; c++) begin
      drive(c != 10 && c != 11, c == 2 || c == 14, 1'b0, 1'b0);
      @(negedge clk);
      if (c == 10) check("abort c10 stage_en", 32'(st8), 32'b0100);
      if (c == 11) begin
        check("abort c11 stage_en", 32'(st8), 32'd0);
        check("abort c11 busy", 32'(bs8), 32'd0);
        check("abort c11 clr_n", 32'(cn8), 32'd0);
        check("abort c11 update_done", 32'(ud8), 32'd0);
      end
      if (c >= 12 && c <= 19) check($sformatf("abort c%0d idle stage_en", c), 32'(st8), 32'd0);
      if (c == 20) check("abort c20 restart stage_en", 32'(st8), 32'd1);
      step();
    end
    gap(2);

    // clear_req for 3 cycles mid-RUN: clr_n low one cycle later, strobes unchanged.
    for (int c = 0; c <= 13; c++) begin
      drive(1'b1, c == 2, c >= 8 && c <= 10, 1'b0);
      @(negedge clk);
      if (c >= 7) begin
        check($sformatf("clrq c%0d clr_n", c), 32'(cn8), 32'(!(c >= 9 && c <= 11)));
        check($sformatf("clrq c%0d stage_en", c), 32'(st8),
              (c >= 8 && c <= 11) ? 32'(1 << (c - 8)) : 32'd0);
      end
      step();
    end
    gap(2);

    // Asynchronous reset in the middle of RUN.
    for (int c = 0; c <= 9; c++) begin
      drive(1'b1, c == 2, 1'b0, 1'b0);
      if (c < 9) step();
    end
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async");
    #3 reset = 1'b0;
    step();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("postrst c%0d stage_en", c), 32'(st8), 32'd0);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("postrst sample stage_en", 32'(st8), 32'd1);
    step();
    gap(2);

    // Random traffic, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
